// File: rtl/add8u_shared_arbiter.sv
// Round-robin arbiter that lets NREQ valid/ready requesters share one
// approximate 8-bit adder, with a single registered result stage.
module add8u_shared_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [8:0]        res_data,
  output logic [IDW-1:0]    res_id,
  input  logic              res_ready,
  output logic [15:0]       busy_cnt
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic [IDW:0]   cand;
  logic           can_accept;
  logic           xfer;
  logic [7:0]     a_sel;
  logic [7:0]     b_sel;
  logic [6:0]     hi_sum;
  logic [8:0]     add_out;

  assign can_accept = !res_valid || res_ready;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ))
        cand = cand - (IDW+1)'(NREQ);
      if (!gnt_any && req_valid[cand[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  assign xfer = gnt_any && can_accept && !rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = xfer && (gnt_idx == IDW'(i));
  end

  assign a_sel = req_a[{gnt_idx, 3'b000} +: 8];
  assign b_sel = req_b[{gnt_idx, 3'b000} +: 8];

  // Approximate adder: low two bits bypass, A[1] feeds the carry-in.
  assign hi_sum  = 7'(a_sel[7:2]) + 7'(b_sel[7:2]) + 7'(a_sel[1]);
  assign add_out = {hi_sum, b_sel[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      ptr       <= '0;
      busy_cnt  <= '0;
    end else begin
      if (xfer) begin
        res_valid <= 1'b1;
        res_data  <= add_out;
        res_id    <= gnt_idx;
        if (gnt_idx == IDW'(NREQ-1))
          ptr <= '0;
        else
          ptr <= gnt_idx + 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
      if ((|req_valid) && !xfer && (busy_cnt != 16'hFFFF))
        busy_cnt <= busy_cnt + 16'd1;
    end
  end

endmodule
